tcnt_axi_sram_slave: RTL and testbench
======================================

# tcnt_axi_sram_slave

Synthesizable AXI4 slave responder backed by an internal word-addressed SRAM array. It sits on the slave end of a `tcnt_axi_interface` bus opposite the VIP master driver, so master-side sequences can run against real RTL without an external memory model. It has independent write (AW/W/B) and read (AR/R) engines, each handling one outstanding burst at a time, with FIXED/INCR bursts and SLVERR signalling.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 64: data width; power of two, 32..1024.
- `ID_WIDTH`, 4: transaction ID width.
- `MEM_DEPTH`, 256: number of `DATA_WIDTH` words.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `DATA_WIDTH/8`.

Ports:
- `aclk` in 1: clock.
- `areset` in 1: synchronous, active-high reset.
- `awvalid` in 1, `awready` out 1, `awid` in ID_WIDTH, `awaddr` in ADDR_WIDTH, `awlen` in 8, `awsize` in 3, `awburst` in 2: write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in DATA_WIDTH, `wstrb` in DATA_WIDTH/8, `wlast` in 1: write data channel.
- `bvalid` out 1, `bready` in 1, `bid` out ID_WIDTH, `bresp` out 2: write response channel.
- `arvalid` in 1, `arready` out 1, `arid` in ID_WIDTH, `araddr` in ADDR_WIDTH, `arlen` in 8, `arsize` in 3, `arburst` in 2: read address channel.
- `rvalid` out 1, `rready` in 1, `rid` out ID_WIDTH, `rdata` out DATA_WIDTH, `rresp` out 2, `rlast` out 1: read data channel.

## Operation
- Bytes per word: NB = DATA_WIDTH/8. Word index = (addr − BASE_ADDR) >> log2(NB). A beat is in range iff BASE_ADDR ≤ addr < BASE_ADDR + MEM_DEPTH·NB.
- Beat addresses: beat 0 = Axaddr. For INCR, beat k = (Axaddr aligned down to 2^size) + k·2^size. For FIXED, every beat = Axaddr. Addresses use ADDR_WIDTH arithmetic; wrap-around past the top of the address space yields out-of-range beats.
- A burst is illegal if it is WRAP (2'b10), reserved (2'b11), or has Axsize > log2(NB).
- Write FSM:
  - W_IDLE: `awready`=1. On AW handshake, latch id/addr/len/size/burst, clear the error flag, and go to W_DATA.
  - W_DATA: `wready`=1. On each W handshake, if the burst is legal and the beat is in range, write the bytes whose `wstrb` bit is set. Otherwise set the error flag. The beat counter counts to awlen.
  - `wlast` must match the final beat. A mismatch on any beat sets the error flag. Beat count alone ends the burst.
  - After the final beat, go to W_RESP.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=2'b10 if the error flag is set, else 2'b00. On B handshake, go to W_IDLE.
- Read FSM:
  - R_IDLE: `arready`=1. On AR handshake, latch the request, load beat 0 into the output register, and go to R_DATA.
  - R_DATA: `rvalid`=1. On R handshake of a non-last beat, load the next beat. On R handshake with `rlast`, go to R_IDLE.
  - Per beat: legal and in range gives `rresp`=00 and `rdata`=mem word. Otherwise `rresp`=10 and `rdata`=0.
  - `rlast`=1 when beat count = arlen.
- The read and write engines are fully independent and can be active simultaneously.
- Memory contents are not reset. Readback before first write is undefined.

## Timing
- Reset values: `awready`=0, `wready`=0, `bvalid`=0, `bid`=0, `bresp`=0, `arready`=0, `rvalid`=0, `rid`=0, `rdata`=0, `rresp`=0, `rlast`=0. The FSMs enter IDLE, and `awready`/`arready` go high in the first cycle after `areset` deasserts.
- AW handshake in cycle N gives `wready`=1 in N+1. The last W beat in cycle M gives `bvalid`=1 in M+1. `awready`=0 from N+1 until the cycle after the B handshake.
- AR handshake in cycle N gives `rvalid`=1 with beat 0 in N+1. With `rready` held at 1, there is one beat per cycle. `arready` returns the cycle after the last R handshake.
- All outputs are registered. Payloads hold stable while valid=1 and ready=0.
- Same-cycle write to the word being loaded into `rdata`: the read returns the old data. A write in an earlier cycle is visible.
- `areset` mid-burst: the burst is aborted, all valid/ready outputs drop the next cycle, and no B or R is issued for the aborted burst. Memory writes already completed are kept.

## Test plan
- INCR write, awaddr=BASE, awlen=3, size=log2(NB), wstrb all ones, data 0x11..0x44 -> bresp=00, bid=awid. INCR read of the same range -> 4 beats 0x11..0x44, rresp=00, rlast on beat 3 only.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with wstrb=8'h0F -> readback 0xFFFF_FFFF_0000_0000.
- Out of range: INCR write of 2 beats starting at the last word -> bresp=10, last word updated. Read of the same addresses -> beat0 rresp=00, beat1 rresp=10 with rdata=0.
- WRAP burst and awsize > log2(NB) -> bresp=10 / rresp=10 on every beat, and memory is unchanged.
- Backpressure plus concurrency: write and read bursts with random `bready`/`rready` stalls -> payloads stable while stalled, correct data, and both engines make progress simultaneously.
- Reset mid-read at beat 2 of 8 -> `rvalid`=0 the next cycle. The next AR is accepted normally.

Source files
------------

// File: rtl/tcnt_axi_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : tcnt_axi_sram_slave_if
// Description : AXI4 bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface tcnt_axi_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/tcnt_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tcnt_axi_sram_slave
// Description : AXI4 slave with independent write/read burst engines over an
//               internal word-addressed SRAM; FIXED/INCR bursts, SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module tcnt_axi_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  wire logic             aclk,
  input  wire logic             areset,
  tcnt_axi_sram_slave_if.slave  axi
);

  localparam int                  c_NB        = DATA_WIDTH / 8;
  localparam int                  c_LOG_NB    = $clog2(c_NB);
  localparam int                  c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]          c_MAX_SIZE  = 3'(c_LOG_NB);
  localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * c_NB);
  localparam logic [ADDR_WIDTH:0] c_ONE       = (ADDR_WIDTH+1)'(1);

  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_INCR  = 2'b01;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  localparam logic [1:0] c_W_IDLE = 2'd0;
  localparam logic [1:0] c_W_DATA = 2'd1;
  localparam logic [1:0] c_W_RESP = 2'd2;
  localparam logic [0:0] c_R_IDLE = 1'b0;
  localparam logic [0:0] c_R_DATA = 1'b1;

  function automatic logic f_legal(input logic [2:0] size, input logic [1:0] burst);
    return ((burst == c_BURST_FIXED) || (burst == c_BURST_INCR)) && (size <= c_MAX_SIZE);
  endfunction

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr, input logic wrapped);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return !wrapped && (addr >= BASE_ADDR) && ({1'b0, off} < c_MEM_BYTES);
  endfunction

  function automatic logic [c_IDX_W-1:0] f_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return c_IDX_W'(off >> c_LOG_NB);
  endfunction

  // Extra MSB carries out of the address space so the burst can be marked as wrapped.
  function automatic logic [ADDR_WIDTH:0] f_next(input logic [ADDR_WIDTH-1:0] addr,
                                                 input logic [2:0] size,
                                                 input logic [1:0] burst);
    logic [ADDR_WIDTH:0] step;
    step = c_ONE << size;
    if (burst == c_BURST_FIXED) return {1'b0, addr};
    return ({1'b0, addr} & ~(step - c_ONE)) + step;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write engine
  logic [1:0]            r_w_state;
  logic                  r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0]   r_aw_id, r_bid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len, r_w_cnt;
  logic [2:0]            r_aw_size;
  logic [1:0]            r_aw_burst;
  logic                  r_aw_wrap, r_w_err;

  logic                  w_aw_hs, w_w_hs, w_b_hs, w_w_last_beat, w_w_ok, w_w_err;
  logic [ADDR_WIDTH:0]   w_w_next;
  logic [c_IDX_W-1:0]    w_w_idx;

  assign w_aw_hs       = axi.awvalid && r_awready;
  assign w_w_hs        = axi.wvalid && r_wready;
  assign w_b_hs        = r_bvalid && axi.bready;
  assign w_w_last_beat = (r_w_cnt == r_aw_len);
  assign w_w_ok        = f_legal(r_aw_size, r_aw_burst) && f_in_range(r_aw_addr, r_aw_wrap);
  assign w_w_err       = !w_w_ok || (axi.wlast != w_w_last_beat);
  assign w_w_next      = f_next(r_aw_addr, r_aw_size, r_aw_burst);
  assign w_w_idx       = f_index(r_aw_addr);

  always_ff @(posedge aclk) begin
    if (!areset && w_w_hs && w_w_ok) begin
      for (int b = 0; b < c_NB; b++) begin
        if (axi.wstrb[b]) r_mem[w_w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_w_state  <= c_W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= '0;
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_wrap  <= 1'b0;
      r_w_cnt    <= '0;
      r_w_err    <= 1'b0;
    end else begin
      case (r_w_state)
        c_W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_aw_id    <= axi.awid;
            r_aw_addr  <= axi.awaddr;
            r_aw_len   <= axi.awlen;
            r_aw_size  <= axi.awsize;
            r_aw_burst <= axi.awburst;
            r_aw_wrap  <= 1'b0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_w_state  <= c_W_DATA;
          end
        end
        c_W_DATA: begin
          if (w_w_hs) begin
            r_aw_addr <= w_w_next[ADDR_WIDTH-1:0];
            r_aw_wrap <= r_aw_wrap | w_w_next[ADDR_WIDTH];
            r_w_cnt   <= r_w_cnt + 8'd1;
            r_w_err   <= r_w_err | w_w_err;
            // Beat count, not wlast, closes the burst.
            if (w_w_last_beat) begin
              r_wready  <= 1'b0;
              r_bvalid  <= 1'b1;
              r_bid     <= r_aw_id;
              r_bresp   <= (r_w_err || w_w_err) ? c_RESP_SLVERR : c_RESP_OKAY;
              r_w_state <= c_W_RESP;
            end
          end
        end
        c_W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_w_state <= c_W_IDLE;
          end
        end
        default: begin
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_w_state <= c_W_IDLE;
        end
      endcase
    end
  end

  assign axi.awready = r_awready;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bid     = r_bid;
  assign axi.bresp   = r_bresp;

  // ---------------------------------------------------------------- read engine
  logic [0:0]            r_r_state;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_ar_len, r_r_cnt;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst;
  logic                  r_ar_wrap;

  logic                  w_ar_hs, w_r_hs;
  logic [ADDR_WIDTH:0]   w_r_next;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic [2:0]            w_ld_size;
  logic [1:0]            w_ld_burst;
  logic                  w_ld_wrap, w_ld_ok;
  logic [7:0]            w_ld_cnt, w_ld_len;
  logic [c_IDX_W-1:0]    w_ld_idx;

  assign w_ar_hs = axi.arvalid && r_arready;
  assign w_r_hs  = r_rvalid && axi.rready;

  // Beat to load into the output register: beat 0 straight from AR, later beats from the latched burst.
  always_comb begin
    w_r_next = f_next(r_ar_addr, r_ar_size, r_ar_burst);
    if (r_r_state == c_R_IDLE) begin
      w_ld_addr  = axi.araddr;
      w_ld_size  = axi.arsize;
      w_ld_burst = axi.arburst;
      w_ld_wrap  = 1'b0;
      w_ld_cnt   = '0;
      w_ld_len   = axi.arlen;
    end else begin
      w_ld_addr  = w_r_next[ADDR_WIDTH-1:0];
      w_ld_size  = r_ar_size;
      w_ld_burst = r_ar_burst;
      w_ld_wrap  = r_ar_wrap | w_r_next[ADDR_WIDTH];
      w_ld_cnt   = r_r_cnt + 8'd1;
      w_ld_len   = r_ar_len;
    end
    w_ld_ok  = f_legal(w_ld_size, w_ld_burst) && f_in_range(w_ld_addr, w_ld_wrap);
    w_ld_idx = f_index(w_ld_addr);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_r_state  <= c_R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_wrap  <= 1'b0;
      r_r_cnt    <= '0;
    end else begin
      case (r_r_state)
        c_R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rid      <= axi.arid;
            r_ar_len   <= axi.arlen;
            r_ar_size  <= axi.arsize;
            r_ar_burst <= axi.arburst;
            r_ar_addr  <= w_ld_addr;
            r_ar_wrap  <= w_ld_wrap;
            r_r_cnt    <= w_ld_cnt;
            r_rdata    <= w_ld_ok ? r_mem[w_ld_idx] : '0;
            r_rresp    <= w_ld_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            r_rlast    <= (w_ld_cnt == w_ld_len);
            r_r_state  <= c_R_DATA;
          end
        end
        c_R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_arready <= 1'b1;
              r_r_state <= c_R_IDLE;
            end else begin
              r_ar_addr <= w_ld_addr;
              r_ar_wrap <= w_ld_wrap;
              r_r_cnt   <= w_ld_cnt;
              r_rdata   <= w_ld_ok ? r_mem[w_ld_idx] : '0;
              r_rresp   <= w_ld_ok ? c_RESP_OKAY : c_RESP_SLVERR;
              r_rlast   <= (w_ld_cnt == w_ld_len);
            end
          end
        end
        default: begin
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_r_state <= c_R_IDLE;
        end
      endcase
    end
  end

  assign axi.arready = r_arready;
  assign axi.rvalid  = r_rvalid;
  assign axi.rid     = r_rid;
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;
  assign axi.rlast   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_tcnt_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcnt_axi_sram_slave
// Description : Directed self-checking bench for tcnt_axi_sram_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcnt_axi_sram_slave;

  localparam logic [1:0] c_FIXED = 2'b00;
  localparam logic [1:0] c_INCR  = 2'b01;
  localparam logic [1:0] c_WRAP  = 2'b10;

  logic aclk;
  logic areset;

  tcnt_axi_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) axi ();

  tcnt_axi_sram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .ID_WIDTH   (4),
    .MEM_DEPTH  (16),
    .BASE_ADDR  (32'h0000_1000)
  ) u_dut (
    .aclk   (aclk),
    .areset (areset),
    .axi    (axi.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_overlap = 0;

  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    else n_pass++;
  endtask

  // Counts cycles where a W and an R handshake are both pending for the same edge.
  always @(negedge aclk) begin
    #2;
    if (axi.wvalid && axi.wready && axi.rvalid && axi.rready) n_overlap++;
  end

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit early_last, input bit stall,
                           output logic [3:0] bid_o, output logic [1:0] bresp_o);
    int t;
    logic [3:0] h_id;
    logic [1:0] h_resp;
    axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr;
    axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    t = 0;
    while (!axi.awready && t < 50) begin @(negedge aclk); t++; end
    check("aw_accept", 64'(axi.awready), 64'd1);
    @(negedge aclk);
    axi.awvalid = 1'b0;
    check("wready_after_aw", 64'(axi.wready), 64'd1);
    check("awready_busy", 64'(axi.awready), 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      axi.wvalid = 1'b1;
      axi.wdata  = wr_data[i];
      axi.wstrb  = wr_strb[i];
      axi.wlast  = early_last ? (i == 0) : (i == int'(len));
      t = 0;
      while (!axi.wready && t < 50) begin @(negedge aclk); t++; end
      @(negedge aclk);
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    check("bvalid_after_last", 64'(axi.bvalid), 64'd1);
    if (stall) begin
      h_id = axi.bid;
      h_resp = axi.bresp;
      repeat ($urandom_range(1, 3)) begin
        @(negedge aclk);
        check("b_stable_id", 64'(axi.bid), 64'(h_id));
        check("b_stable_resp", 64'(axi.bresp), 64'(h_resp));
      end
    end
    bid_o   = axi.bid;
    bresp_o = axi.bresp;
    axi.bready = 1'b1;
    @(negedge aclk);
    axi.bready = 1'b0;
    check("awready_after_b", 64'(axi.awready), 64'd1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int t;
    int beat;
    bit held;
    logic [63:0] h_data;
    logic [1:0]  h_resp;
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr;
    axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    t = 0;
    while (!axi.arready && t < 50) begin @(negedge aclk); t++; end
    check("ar_accept", 64'(axi.arready), 64'd1);
    @(negedge aclk);
    axi.arvalid = 1'b0;
    check("rvalid_after_ar", 64'(axi.rvalid), 64'd1);
    check("arready_busy", 64'(axi.arready), 64'd0);
    beat = 0; t = 0; held = 0; h_data = '0; h_resp = '0;
    while (beat <= int'(len) && t < 500) begin
      if (axi.rvalid) begin
        if (held) begin
          check("r_stable_data", axi.rdata, h_data);
          check("r_stable_resp", 64'(axi.rresp), 64'(h_resp));
        end
        if (stall && beat > 0 && $urandom_range(0, 2) == 0) begin
          axi.rready = 1'b0;
          held = 1; h_data = axi.rdata; h_resp = axi.rresp;
        end else begin
          axi.rready = 1'b1;
          rd_data[beat] = axi.rdata;
          rd_resp[beat] = axi.rresp;
          rd_last[beat] = axi.rlast;
          rd_id[beat]   = axi.rid;
          beat++;
          held = 0;
        end
      end else begin
        axi.rready = 1'b0;
      end
      @(negedge aclk);
      t++;
    end
    axi.rready = 1'b0;
    check("r_beats", 64'(beat), 64'(int'(len) + 1));
    check("arready_after_r", 64'(axi.arready), 64'd1);
    check("rvalid_after_r", 64'(axi.rvalid), 64'd0);
  endtask

  logic [3:0] bid;
  logic [1:0] bresp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.rready = 0;
    for (int i = 0; i < 16; i++) begin wr_data[i] = '0; wr_strb[i] = 8'hFF; end

    repeat (3) @(negedge aclk);
    check("rst_awready", 64'(axi.awready), 64'd0);
    check("rst_wready",  64'(axi.wready),  64'd0);
    check("rst_bvalid",  64'(axi.bvalid),  64'd0);
    check("rst_bid",     64'(axi.bid),     64'd0);
    check("rst_bresp",   64'(axi.bresp),   64'd0);
    check("rst_arready", 64'(axi.arready), 64'd0);
    check("rst_rvalid",  64'(axi.rvalid),  64'd0);
    check("rst_rid",     64'(axi.rid),     64'd0);
    check("rst_rdata",   axi.rdata,        64'd0);
    check("rst_rresp",   64'(axi.rresp),   64'd0);
    check("rst_rlast",   64'(axi.rlast),   64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("awready_post_rst", 64'(axi.awready), 64'd1);
    check("arready_post_rst", 64'(axi.arready), 64'd1);

    // INCR write/read of words 0..3
    wr_data[0] = 64'h11; wr_data[1] = 64'h22; wr_data[2] = 64'h33; wr_data[3] = 64'h44;
    axi_write(4'h5, 32'h1000, 8'd3, 3'd3, c_INCR, 0, 0, bid, bresp);
    check("incr_bresp", 64'(bresp), 64'd0);
    check("incr_bid", 64'(bid), 64'h5);
    axi_read(4'h9, 32'h1000, 8'd3, 3'd3, c_INCR, 0);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rd_data[i], 64'(8'h11 * (i + 1)));
      check("incr_rresp", 64'(rd_resp[i]), 64'd0);
      check("incr_rlast", 64'(rd_last[i]), 64'(i == 3));
      check("incr_rid", 64'(rd_id[i]), 64'h9);
    end

    // Partial strobe on word 4
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(4'h1, 32'h1020, 8'd0, 3'd3, c_INCR, 0, 0, bid, bresp);
    wr_data[0] = 64'h0; wr_strb[0] = 8'h0F;
    axi_write(4'h1, 32'h1020, 8'd0, 3'd3, c_INCR, 0, 0, bid, bresp);
    wr_strb[0] = 8'hFF;
    axi_read(4'h2, 32'h1020, 8'd0, 3'd3, c_INCR, 0);
    check("strb_rdata", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    // Out of range: starts on last word (15), second beat falls off the end
    wr_data[0] = 64'hA1; wr_data[1] = 64'hA2;
    axi_write(4'h3, 32'h1078, 8'd1, 3'd3, c_INCR, 0, 0, bid, bresp);
    check("oor_bresp", 64'(bresp), 64'd2);
    axi_read(4'h3, 32'h1078, 8'd1, 3'd3, c_INCR, 0);
    check("oor_rdata0", rd_data[0], 64'hA1);
    check("oor_rresp0", 64'(rd_resp[0]), 64'd0);
    check("oor_rdata1", rd_data[1], 64'd0);
    check("oor_rresp1", 64'(rd_resp[1]), 64'd2);
    check("oor_rlast1", 64'(rd_last[1]), 64'd1);

    // Illegal bursts: WRAP and oversize must not touch memory
    wr_data[0] = 64'hDEAD; wr_data[1] = 64'hBEEF;
    axi_write(4'h4, 32'h1000, 8'd1, 3'd3, c_WRAP, 0, 0, bid, bresp);
    check("wrap_bresp", 64'(bresp), 64'd2);
    wr_data[0] = 64'hBAD;
    axi_write(4'h4, 32'h1008, 8'd0, 3'd4, c_INCR, 0, 0, bid, bresp);
    check("size_bresp", 64'(bresp), 64'd2);
    axi_read(4'h4, 32'h1000, 8'd1, 3'd3, c_INCR, 0);
    check("illegal_mem0", rd_data[0], 64'h11);
    check("illegal_mem1", rd_data[1], 64'h22);
    axi_read(4'h4, 32'h1000, 8'd1, 3'd3, c_WRAP, 0);
    for (int i = 0; i < 2; i++) begin
      check("wrap_rresp", 64'(rd_resp[i]), 64'd2);
      check("wrap_rdata", rd_data[i], 64'd0);
    end
    axi_read(4'h4, 32'h1008, 8'd0, 3'd4, c_INCR, 0);
    check("size_rresp", 64'(rd_resp[0]), 64'd2);
    check("size_rdata", rd_data[0], 64'd0);

    // FIXED burst: all beats hit word 6, last one wins
    wr_data[0] = 64'h1; wr_data[1] = 64'h2; wr_data[2] = 64'h3;
    axi_write(4'h6, 32'h1030, 8'd2, 3'd3, c_FIXED, 0, 0, bid, bresp);
    check("fixed_bresp", 64'(bresp), 64'd0);
    axi_read(4'h6, 32'h1030, 8'd1, 3'd3, c_FIXED, 0);
    check("fixed_rdata0", rd_data[0], 64'h3);
    check("fixed_rdata1", rd_data[1], 64'h3);

    // Early wlast: error response, data still written to words 7,8
    wr_data[0] = 64'h77; wr_data[1] = 64'h88;
    axi_write(4'h7, 32'h1038, 8'd1, 3'd3, c_INCR, 1, 0, bid, bresp);
    check("wlast_bresp", 64'(bresp), 64'd2);
    axi_read(4'h7, 32'h1038, 8'd1, 3'd3, c_INCR, 0);
    check("wlast_rdata0", rd_data[0], 64'h77);
    check("wlast_rdata1", rd_data[1], 64'h88);

    // Narrow INCR (4-byte beats) starting mid-word 9, second beat in word 10
    wr_data[0] = 64'h0; wr_data[1] = 64'h0;
    axi_write(4'h8, 32'h1048, 8'd1, 3'd3, c_INCR, 0, 0, bid, bresp);
    wr_data[0] = 64'h1234_5678_0000_0000; wr_strb[0] = 8'hF0;
    wr_data[1] = 64'h0000_0000_9ABC_DEF0; wr_strb[1] = 8'h0F;
    axi_write(4'h8, 32'h104C, 8'd1, 3'd2, c_INCR, 0, 0, bid, bresp);
    wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    check("narrow_bresp", 64'(bresp), 64'd0);
    axi_read(4'h8, 32'h1048, 8'd1, 3'd3, c_INCR, 0);
    check("narrow_rdata0", rd_data[0], 64'h1234_5678_0000_0000);
    check("narrow_rdata1", rd_data[1], 64'h0000_0000_9ABC_DEF0);

    // Concurrent write (words 11..14) and read (words 0..3) with stalls
    for (int i = 0; i < 4; i++) wr_data[i] = 64'hC0 + 64'(i);
    n_overlap = 0;
    fork
      axi_write(4'hC, 32'h1058, 8'd3, 3'd3, c_INCR, 0, 1, bid, bresp);
      axi_read(4'hD, 32'h1000, 8'd3, 3'd3, c_INCR, 1);
    join
    check("conc_bresp", 64'(bresp), 64'd0);
    check("conc_bid", 64'(bid), 64'hC);
    for (int i = 0; i < 4; i++) check("conc_rdata", rd_data[i], 64'(8'h11 * (i + 1)));
    check("conc_overlap", 64'(n_overlap > 0), 64'd1);
    axi_read(4'hE, 32'h1058, 8'd3, 3'd3, c_INCR, 1);
    for (int i = 0; i < 4; i++) check("conc_wdata", rd_data[i], 64'hC0 + 64'(i));

    // Reset while beat 2 of an 8-beat read is on the bus
    check("rr_arready", 64'(axi.arready), 64'd1);
    axi.arvalid = 1'b1; axi.arid = 4'hA; axi.araddr = 32'h1000;
    axi.arlen = 8'd7; axi.arsize = 3'd3; axi.arburst = c_INCR;
    @(negedge aclk);
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    check("rr_beat0", axi.rdata, 64'h11);
    @(negedge aclk);
    check("rr_beat1", axi.rdata, 64'h22);
    @(negedge aclk);
    check("rr_beat2", axi.rdata, 64'h33);
    axi.rready = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    check("rr_rvalid_low", 64'(axi.rvalid), 64'd0);
    check("rr_arready_low", 64'(axi.arready), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("rr_arready_back", 64'(axi.arready), 64'd1);
    check("rr_rvalid_idle", 64'(axi.rvalid), 64'd0);
    axi_read(4'hB, 32'h1010, 8'd0, 3'd3, c_INCR, 0);
    check("rr_after_data", rd_data[0], 64'h33);
    check("rr_after_rlast", 64'(rd_last[0]), 64'd1);
    check("rr_after_rid", 64'(rd_id[0]), 64'hB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
